alu_result_stage: RTL and testbench

- Execute-to-writeback stage that sits directly downstream of the 8-bit ALU.
- Captures ALU result and compare outputs (out, equal, less) together with instruction side-band: destination register, write enable, flag-set request and branch type.
- Holds a persistent flag register (EQ, LT) that compare instructions update and branch instructions read. Branches are resolved at capture time.
- Provides a valid/ready handshake on both sides, with a 2-entry skid buffer so upstream stalls only when both entries are occupied.

---
 rtl/alu_result_stage.sv | 112 +++++++++++
 tb/tb_alu_result_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage: execute-to-writeback stage with flag register, branch resolve and 2-entry skid buffer
module alu_result_stage #(
   parameter int DATA_W  = 8,
   parameter int RADDR_W = 3
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  alu_out,
   input  logic               alu_equal,
   input  logic               alu_less,
   input  logic [RADDR_W-1:0] in_dest,
   input  logic               in_wr_en,
   input  logic               in_set_flags,
   input  logic [1:0]         in_branch,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic [RADDR_W-1:0] out_dest,
   output logic               out_wr_en,
   output logic               out_branch_taken,
   output logic               flag_eq,
   output logic               flag_lt
);
   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   logic [1:0]         state;
   logic [DATA_W-1:0]  head_data, skid_data;
   logic [RADDR_W-1:0] head_dest, skid_dest;
   logic               head_wr, skid_wr, head_tk, skid_tk;
   logic               accept, drain, taken, load_head, load_skid, skid_to_head;

   // in_ready and out_valid come straight from the occupancy register
   assign in_ready  = state != FULL;
   assign out_valid = state != EMPTY;
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid && out_ready;

   // Branch decision uses the flags as they stand before this beat updates them
   assign taken = (in_branch == 2'b11) || (in_branch == 2'b01 && flag_eq) || (in_branch == 2'b10 && flag_lt);

   // New beat goes to head when the head slot is free (or being freed), else to skid
   assign load_head    = accept && (state == EMPTY || (state == ONE && drain));
   assign load_skid    = accept && state == ONE && !drain;
   assign skid_to_head = drain && state == FULL;

   assign out_data         = head_data;
   assign out_dest         = head_dest;
   assign out_wr_en        = head_wr && out_valid;
   assign out_branch_taken = head_tk && out_valid;

   // Occupancy state machine
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= EMPTY;
      else if (state == EMPTY)
         state <= accept ? ONE : EMPTY;
      else if (state == ONE)
         state <= (accept && !drain) ? FULL : (drain && !accept) ? EMPTY : ONE;
      else
         state <= drain ? ONE : FULL;
   end

   // Head entry: loaded from the input or promoted from the skid entry
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_data <= '0;
         head_dest <= '0;
         head_wr   <= 1'b0;
         head_tk   <= 1'b0;
      end else if (load_head) begin
         head_data <= alu_out;
         head_dest <= in_dest;
         head_wr   <= in_wr_en;
         head_tk   <= taken;
      end else if (skid_to_head) begin
         head_data <= skid_data;
         head_dest <= skid_dest;
         head_wr   <= skid_wr;
         head_tk   <= skid_tk;
      end
   end

   // Skid entry: catches the beat accepted while the head is stalled
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         skid_data <= '0;
         skid_dest <= '0;
         skid_wr   <= 1'b0;
         skid_tk   <= 1'b0;
      end else if (load_skid) begin
         skid_data <= alu_out;
         skid_dest <= in_dest;
         skid_wr   <= in_wr_en;
         skid_tk   <= taken;
      end
   end

   // Persistent flags change only on an accepted flag-setting beat
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flag_eq <= 1'b0;
         flag_lt <= 1'b0;
      end else if (accept && in_set_flags) begin
         flag_eq <= alu_equal;
         flag_lt <= alu_less;
      end
   end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: randomized and directed checks against a queue-based reference model
module tb_alu_result_stage;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       in_valid = 1'b0, in_ready;
   logic [7:0] alu_out = '0;
   logic       alu_equal = 1'b0, alu_less = 1'b0;
   logic [2:0] in_dest = '0;
   logic       in_wr_en = 1'b0, in_set_flags = 1'b0;
   logic [1:0] in_branch = '0;
   logic       out_valid, out_ready = 1'b0;
   logic [7:0] out_data;
   logic [2:0] out_dest;
   logic       out_wr_en, out_branch_taken, flag_eq, flag_lt;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [7:0] d;
      logic [2:0] dst;
      logic       wr;
      logic       tk;
   } ent_t;
   ent_t q[$];
   logic m_eq = 1'b0, m_lt = 1'b0;

   alu_result_stage #(.DATA_W(8), .RADDR_W(3)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_out(alu_out), .alu_equal(alu_equal), .alu_less(alu_less),
      .in_dest(in_dest), .in_wr_en(in_wr_en), .in_set_flags(in_set_flags),
      .in_branch(in_branch), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_dest(out_dest), .out_wr_en(out_wr_en),
      .out_branch_taken(out_branch_taken), .flag_eq(flag_eq), .flag_lt(flag_lt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Compare every observable output against the model's view of the stage
   task automatic check_model();
      chk("out_valid", out_valid, q.size() > 0);
      chk("in_ready", in_ready, q.size() < 2);
      chk("flag_eq", flag_eq, m_eq);
      chk("flag_lt", flag_lt, m_lt);
      if (q.size() > 0) begin
         chk("out_data", out_data, q[0].d);
         chk("out_dest", out_dest, q[0].dst);
         chk("out_wr_en", out_wr_en, q[0].wr);
         chk("out_taken", out_branch_taken, q[0].tk);
      end else begin
         chk("idle_wr_en", out_wr_en, 0);
         chk("idle_taken", out_branch_taken, 0);
      end
   endtask

   // One clock: check at negedge, drive inputs, then advance the model at posedge
   task automatic step(input logic v, input logic [7:0] d, input logic eq, input logic lt,
                       input logic [2:0] dst, input logic wr, input logic sf,
                       input logic [1:0] br, input logic ordy);
      logic acc, drn, tk;
      ent_t e;
      @(negedge clk);
      check_model();
      in_valid = v; alu_out = d; alu_equal = eq; alu_less = lt;
      in_dest = dst; in_wr_en = wr; in_set_flags = sf; in_branch = br; out_ready = ordy;
      acc = v && q.size() < 2;
      drn = q.size() > 0 && ordy;
      tk = (br == 2'd3) ? 1'b1 : (br == 2'd1) ? m_eq : (br == 2'd2) ? m_lt : 1'b0;
      @(posedge clk);
      if (drn) void'(q.pop_front());
      if (acc) begin
         e.d = d; e.dst = dst; e.wr = wr; e.tk = tk;
         q.push_back(e);
         if (sf) begin
            m_eq = eq;
            m_lt = lt;
         end
      end
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, ordy);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_data", out_data, 0);
      chk("rst_flags", {flag_eq, flag_lt}, 0);
      reset_n = 1'b1;

      // Single beat, then empty again
      step(1'b1, 8'h3C, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 2'd0, 1'b1);
      #1;
      chk("single_valid", out_valid, 1);
      chk("single_data", out_data, 8'h3C);
      chk("single_dest", out_dest, 5);
      chk("single_wr", out_wr_en, 1);
      idle(1'b1);
      #1;
      chk("single_gone", out_valid, 0);

      // Back-pressure: third beat must be held upstream until space appears
      step(1'b1, 8'h11, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 2'd0, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 2'd0, 1'b0);
      #1;
      chk("bp_full", in_ready, 0);
      step(1'b1, 8'h33, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 2'd0, 1'b0);
      step(1'b1, 8'h33, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 2'd0, 1'b1);
      #1;
      chk("bp_head2", out_data, 8'h22);
      step(1'b1, 8'h33, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 2'd0, 1'b1);
      #1;
      chk("bp_head3", out_data, 8'h33);
      repeat (2) idle(1'b1);

      // Flags then branches
      step(1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 2'd0, 1'b1);
      #1;
      chk("cmp_flag_eq", flag_eq, 1);
      step(1'b1, 8'h01, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd1, 1'b1);
      #1;
      chk("beq_taken", out_branch_taken, 1);
      step(1'b1, 8'h02, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd2, 1'b1);
      #1;
      chk("blt_not_taken", out_branch_taken, 0);

      // Same-beat hazard: branch sees old EQ=0 while the beat sets EQ=1
      step(1'b1, 8'h03, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 2'd0, 1'b1);
      step(1'b1, 8'h04, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 2'd1, 1'b1);
      #1;
      chk("hazard_taken", out_branch_taken, 0);
      chk("hazard_flag", flag_eq, 1);
      idle(1'b1);

      // Streaming at full rate
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 8'(i), 1'b0, 1'b0, 3'(i), 1'b1, 1'b0, 2'd0, 1'b1);
         #1;
         chk("stream_data", out_data, i);
         chk("stream_ready", in_ready, 1);
      end
      idle(1'b1);

      // Random traffic
      for (int i = 0; i < 400; i++)
         step(($urandom % 4) != 0, 8'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
              1'($urandom), 1'($urandom), 2'($urandom), ($urandom % 3) != 0);

      // Asynchronous reset while FULL with flags set
      idle(1'b1);
      idle(1'b1);
      step(1'b1, 8'hAA, 1'b1, 1'b1, 3'd6, 1'b1, 1'b1, 2'd3, 1'b0);
      step(1'b1, 8'hBB, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1, 2'd3, 1'b0);
      #1;
      chk("pre_rst_full", in_ready, 0);
      chk("pre_rst_flags", {flag_eq, flag_lt}, 3);
      #1 reset_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_ready", in_ready, 1);
      chk("arst_flags", {flag_eq, flag_lt}, 0);
      chk("arst_data", out_data, 0);
      chk("arst_wr", out_wr_en, 0);
      q.delete();
      m_eq = 1'b0;
      m_lt = 1'b0;
      in_valid = 1'b0;
      #1 reset_n = 1'b1;
      repeat (3) idle(1'b1);
      @(negedge clk);
      check_model();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
